if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, handles branch redirects and freezes.
// Optional performance counters (fetch_count, wait_count) are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
`endif
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        PC           = 32'd0;
        instruction  = 32'd0;
        if_valid     = 1'b0;

        case (state_q)
            ST_REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d = branch_addr;
                    // The outstanding request cannot be withdrawn, so remember it and drain its ack.
                    if (!imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    if_valid    = 1'b1;
                    PC          = pc_plus4;
                    instruction = imem_rdata;
                    if (freeze) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_plus4;
                        state_d      = ST_HOLD;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    state_d = ST_REQ;
                end else begin
                    if_valid    = 1'b1;
                    PC          = hold_pc_q;
                    instruction = hold_instr_q;
                    if (!freeze) begin
                        pc_d    = hold_pc_q;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (branch_taken) begin
                    pc_d = branch_addr;
                end
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (rst) begin
            imem_req    = 1'b0;
            PC          = 32'd0;
            instruction = 32'd0;
            if_valid    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'd0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] wait_count_q, wait_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, (if_valid && !freeze)};
        wait_count_d  = wait_count_q + {31'd0, (imem_req && !imem_ack)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'd0;
            wait_count_q  <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            wait_count_q  <= wait_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign wait_count  = wait_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: a transaction-level fetch model plus literal spot checks.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC_TB = 32'hFFFF_FFF8;
    localparam logic [31:0] DATA_KEY    = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    if_fetch_stage #(.RESET_PC(RESET_PC_TB)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .instruction (instruction),
        .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .wait_count  (wait_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory responder: acks once the request has been up for mem_wait cycles.
    int mem_wait = 0;
    int mem_cnt  = 0;

    // Fetch model: next address, an abandoned request to drain, and a one-deep held-instruction queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } held_t;

    logic [31:0] m_next     = RESET_PC_TB;
    logic        m_draining = 1'b0;
    logic [31:0] m_drain    = 32'd0;
    held_t       m_held[$];

    logic        exp_req   = 1'b0;
    logic [31:0] exp_addr  = 32'd0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_pc    = 32'd0;
    logic [31:0] exp_instr = 32'd0;
    bit          model_armed = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic runModel();
        exp_req   = 1'b0;
        exp_addr  = 32'd0;
        exp_valid = 1'b0;
        exp_pc    = 32'd0;
        exp_instr = 32'd0;
        if (rst) begin
            m_next     = RESET_PC_TB;
            m_draining = 1'b0;
            m_held.delete();
        end else if (m_held.size() != 0) begin
            if (branch_taken) begin
                m_held.delete();
                m_next = branch_addr;
            end else begin
                exp_valid = 1'b1;
                exp_pc    = m_held[0].pc;
                exp_instr = m_held[0].instr;
                if (!freeze) begin
                    m_next = m_held[0].pc;
                    m_held.delete();
                end
            end
        end else if (m_draining) begin
            exp_req  = 1'b1;
            exp_addr = m_drain;
            if (branch_taken) m_next = branch_addr;
            if (imem_ack) m_draining = 1'b0;
        end else begin
            exp_req  = 1'b1;
            exp_addr = m_next;
            if (branch_taken) begin
                if (!imem_ack) begin
                    m_draining = 1'b1;
                    m_drain    = m_next;
                end
                m_next = branch_addr;
            end else if (imem_ack) begin
                exp_valid = 1'b1;
                exp_pc    = m_next + 32'd4;
                exp_instr = imem_rdata;
                if (freeze) m_held.push_back(held_t'{pc: m_next + 32'd4, instr: imem_rdata});
                else m_next = m_next + 32'd4;
            end
        end
    endtask

    // One cycle: drive controls, let memory answer, then evaluate the model before the edge.
    task automatic applyStimulus(input logic r, input logic f, input logic b, input logic [31:0] ba);
        @(posedge clk);
        #1;
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        #1;
        imem_ack   = imem_req && (mem_cnt == mem_wait);
        imem_rdata = imem_ack ? (imem_addr ^ DATA_KEY) : 32'hDEAD_BEEF;
        #1;
        runModel();
        model_armed = 1'b1;
        mem_cnt = (!imem_req || imem_ack) ? 0 : mem_cnt + 1;
    endtask

    always @(negedge clk) begin
        if (model_armed) begin
            checkOutput("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (exp_req) checkOutput("imem_addr", imem_addr, exp_addr);
            checkOutput("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
            checkOutput("PC", PC, exp_pc);
            checkOutput("instruction", instruction, exp_instr);
        end
    end

    logic [31:0] addr_tab[4];
    logic [31:0] pc_tab[4];

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        addr_tab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        pc_tab   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("lit_rst_pc", PC, 32'd0);

        // Zero-wait stream across the 32-bit wrap.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            checkOutput("lit_zw_addr", imem_addr, addr_tab[i]);
            checkOutput("lit_zw_pc", PC, pc_tab[i]);
        end
        checkOutput("lit_zw_instr", instruction, 32'hE000_0004);

        // Completion at 8 under freeze, held for three cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("lit_frz_addr", imem_addr, 32'h8);
        checkOutput("lit_frz_pc", PC, 32'hC);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b0, 32'd0);
            checkOutput("lit_hold_req", {31'd0, imem_req}, 32'd0);
            checkOutput("lit_hold_pc", PC, 32'hC);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_resume_addr", imem_addr, 32'hC);
        checkOutput("lit_resume_pc", PC, 32'h10);

        // Two wait cycles per fetch.
        mem_wait = 2;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            if (i % 3 == 2) checkOutput("lit_w2_pc", PC, 32'h14 + 32'(4 * (i / 3)));
            else checkOutput("lit_w2_bubble", PC, 32'd0);
        end

        // Branch while the fetch at 0x1C is outstanding.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
`ifdef IF_PERF_CNT_EN
        checkOutput("lit_wait_count", wait_count, 32'd6);
        checkOutput("lit_fetch_count", fetch_count, 32'd9);
`endif
        checkOutput("lit_br_addr", imem_addr, 32'h1C);
        checkOutput("lit_br_valid", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_drain_addr", imem_addr, 32'h1C);
        checkOutput("lit_drain_instr", instruction, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_tgt_addr", imem_addr, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_tgt_pc", PC, 32'h104);

        // Branch with freeze while holding.
        mem_wait = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("lit_h2_pc", PC, 32'h108);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        checkOutput("lit_h2_drop", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_h2_addr", imem_addr, 32'h200);
        checkOutput("lit_h2_tpc", PC, 32'h204);

        // Branch in the same cycle as an ack.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h300);
        checkOutput("lit_ba_valid", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_ba_addr", imem_addr, 32'h300);

        // Second branch while draining takes the newest target.
        mem_wait = 2;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h400);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h500);
        checkOutput("lit_dd_addr", imem_addr, 32'h304);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_dd_tgt", imem_addr, 32'h500);

        // Reset in the middle of a wait.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_mr_req", {31'd0, imem_req}, 32'd0);
        mem_wait = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_mr_addr", imem_addr, 32'hFFFF_FFF8);
        checkOutput("lit_mr_pc", PC, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("lit_mr_wrap", PC, 32'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
